// File: rtl/vga_clk_cfg_slave.sv
// vga_clk_cfg_slave: AXI4-Lite clocking-wizard reconfig subset (CFG 0x208, CTRL 0x25C, STATUS 0x004) with relock model.
// Define VGA_CFG_SLV_READ_EN to return register contents on the read channel; otherwise reads return 0/OKAY.
module vga_clk_cfg_slave #(
   parameter int         LOCK_CYCLES = 64,
   parameter logic [7:0] RESET_INT   = 8'd25,
   parameter logic [9:0] RESET_FRAC  = 10'd0
) (
   input  logic        clk_100m_i,
   input  logic        arstn_i,
   input  logic [10:0] s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [10:0] s_axi_araddr,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [7:0]  div_int_o,
   output logic [9:0]  div_frac_o,
   output logic        cfg_update_o,
   output logic        locked_o
);
   localparam logic [10:0] ADDR_STATUS = 11'h004;
   localparam logic [10:0] ADDR_CFG    = 11'h208;
   localparam logic [10:0] ADDR_CTRL   = 11'h25C;
   localparam int CW = $clog2(LOCK_CYCLES + 1);
   localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYCLES);

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_RESP} r_state_t;
   typedef enum logic {RELOCK, LOCKED} l_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;
   l_state_t l_state, l_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [10:0] aw_q, wr_addr;
   logic [31:0] wd_q, wr_data;
   logic [3:0]  ws_q, wr_strb;
   logic [7:0]  sh_int;
   logic [9:0]  sh_frac;
   logic [1:0]  wr_resp;
   logic        aw_hs, w_hs, ar_hs, wr_do, cfg_wr, commit;
   logic        unused_bits;

   assign s_axi_awready = (w_state == W_IDLE) || (w_state == W_HAVE_W);
   assign s_axi_wready  = (w_state == W_IDLE) || (w_state == W_HAVE_AW);
   assign s_axi_bvalid  = (w_state == W_RESP);
   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;

   // The write lands on whichever edge completes the AW/W pair; the earlier half comes from its holding register.
   assign wr_addr = (w_state == W_HAVE_AW) ? aw_q : s_axi_awaddr;
   assign wr_data = (w_state == W_HAVE_W) ? wd_q : s_axi_wdata;
   assign wr_strb = (w_state == W_HAVE_W) ? ws_q : s_axi_wstrb;
   assign wr_resp = (wr_addr inside {ADDR_STATUS, ADDR_CFG, ADDR_CTRL}) ? 2'b00 : 2'b10;
   assign cfg_wr  = wr_do && (wr_addr == ADDR_CFG);
   assign commit  = wr_do && (wr_addr == ADDR_CTRL) && (wr_data[1:0] == 2'b11);
   assign unused_bits = ^{wr_data[31:18], wr_strb[3]};

   always_comb begin
      w_next = w_state;
      wr_do  = 1'b0;
      case (w_state)
         W_IDLE: begin
            wr_do  = aw_hs && w_hs;
            w_next = wr_do ? W_RESP : aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : W_IDLE;
         end
         W_HAVE_AW: begin
            wr_do  = w_hs;
            w_next = w_hs ? W_RESP : W_HAVE_AW;
         end
         W_HAVE_W: begin
            wr_do  = aw_hs;
            w_next = aw_hs ? W_RESP : W_HAVE_W;
         end
         W_RESP:  w_next = s_axi_bready ? W_IDLE : W_RESP;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk_100m_i or negedge arstn_i) begin
      if (!arstn_i) begin
         w_state     <= W_IDLE;
         aw_q        <= '0;
         wd_q        <= '0;
         ws_q        <= '0;
         s_axi_bresp <= 2'b00;
      end else begin
         w_state <= w_next;
         if (aw_hs) aw_q <= s_axi_awaddr;
         if (w_hs) begin
            wd_q <= s_axi_wdata;
            ws_q <= s_axi_wstrb;
         end
         if (wr_do) s_axi_bresp <= wr_resp;
      end
   end

   always_ff @(posedge clk_100m_i or negedge arstn_i) begin
      if (!arstn_i) begin
         sh_int       <= RESET_INT;
         sh_frac      <= RESET_FRAC;
         div_int_o    <= RESET_INT;
         div_frac_o   <= RESET_FRAC;
         cfg_update_o <= 1'b0;
      end else begin
         if (cfg_wr && wr_strb[0]) sh_int <= wr_data[7:0];
         if (cfg_wr && wr_strb[1]) sh_frac[7:0] <= wr_data[15:8];
         if (cfg_wr && wr_strb[2]) sh_frac[9:8] <= wr_data[17:16];
         if (commit) begin
            div_int_o  <= sh_int;
            div_frac_o <= sh_frac;
         end
         cfg_update_o <= commit;
      end
   end

   // A commit always (re)starts the relock window, even from LOCKED.
   always_comb begin
      l_next   = l_state;
      cnt_next = cnt;
      if (commit) begin
         l_next   = RELOCK;
         cnt_next = LOCK_LOAD;
      end else if (l_state == RELOCK) begin
         l_next   = (cnt == '0) ? LOCKED : RELOCK;
         cnt_next = (cnt == '0) ? cnt : cnt - CW'(1);
      end
   end

   always_ff @(posedge clk_100m_i or negedge arstn_i) begin
      if (!arstn_i) begin
         l_state <= RELOCK;
         cnt     <= LOCK_LOAD;
      end else begin
         l_state <= l_next;
         cnt     <= cnt_next;
      end
   end

   assign locked_o = (l_state == LOCKED);

   assign s_axi_arready = (r_state == R_IDLE);
   assign s_axi_rvalid  = (r_state == R_RESP);
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   always_comb r_next = (r_state == R_IDLE) ? (s_axi_arvalid ? R_RESP : R_IDLE)
                                            : (s_axi_rready ? R_IDLE : R_RESP);

   always_ff @(posedge clk_100m_i or negedge arstn_i) begin
      if (!arstn_i) r_state <= R_IDLE;
      else          r_state <= r_next;
   end

`ifdef VGA_CFG_SLV_READ_EN
   logic [31:0] rd_mux;
   logic [1:0]  rd_resp;

   always_comb begin
      rd_mux  = (s_axi_araddr == ADDR_CFG)    ? {14'b0, sh_frac, sh_int} :
                (s_axi_araddr == ADDR_STATUS) ? {31'b0, locked_o} : 32'b0;
      rd_resp = (s_axi_araddr inside {ADDR_STATUS, ADDR_CFG, ADDR_CTRL}) ? 2'b00 : 2'b10;
   end

   always_ff @(posedge clk_100m_i or negedge arstn_i) begin
      if (!arstn_i) begin
         s_axi_rdata <= '0;
         s_axi_rresp <= 2'b00;
      end else if (ar_hs) begin
         s_axi_rdata <= rd_mux;
         s_axi_rresp <= rd_resp;
      end
   end
`else
   logic unused_rd;
   assign unused_rd   = ^{s_axi_araddr, ar_hs};
   assign s_axi_rdata = '0;
   assign s_axi_rresp = 2'b00;
`endif
endmodule

// File: tb/tb_vga_clk_cfg_slave.sv
// tb_vga_clk_cfg_slave: directed plus randomized AXI4-Lite traffic checked every cycle against a transaction-level model.
module tb_vga_clk_cfg_slave;
   localparam int LC = 64;

   logic        clk = 1'b0;
   logic        arstn_i;
   logic [10:0] s_axi_awaddr;
   logic        s_axi_awvalid, s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid, s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid, s_axi_bready;
   logic [10:0] s_axi_araddr;
   logic        s_axi_arvalid, s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid, s_axi_rready;
   logic [7:0]  div_int_o;
   logic [9:0]  div_frac_o;
   logic        cfg_update_o, locked_o;

   always #5 clk = ~clk;

   vga_clk_cfg_slave #(.LOCK_CYCLES(LC), .RESET_INT(8'd25), .RESET_FRAC(10'd0)) dut (
      .clk_100m_i(clk), .arstn_i(arstn_i),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .div_int_o(div_int_o), .div_frac_o(div_frac_o), .cfg_update_o(cfg_update_o), .locked_o(locked_o)
   );

   int vectors = 0;
   int miscmp = 0;
   int upd_cnt = 0;
   bit chk_en = 1'b0;

   // Model state after the most recent rising edge; n counts edges since reset release.
   bit          m_aw, m_w, m_b, m_r, m_upd;
   logic [10:0] m_awaddr;
   logic [31:0] m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;
   logic [7:0]  m_sh_int, m_int;
   logic [9:0]  m_sh_frac, m_frac;
   int          n, m_commit;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_init();
      {m_aw, m_w, m_b, m_r, m_upd} = '0;
      m_awaddr = '0; m_wdata = '0; m_wstrb = '0; m_rdata = '0;
      m_bresp = 2'b00; m_rresp = 2'b00;
      m_sh_int = 8'd25; m_int = 8'd25; m_sh_frac = 10'd0; m_frac = 10'd0;
      n = 0; m_commit = 0;
   endtask

   task automatic model_step();
      bit ah, wh, rh, lk;
      ah = s_axi_awvalid && !m_aw && !m_b;
      wh = s_axi_wvalid && !m_w && !m_b;
      rh = s_axi_arvalid && !m_r;
      lk = (n - m_commit) > LC;
      if (m_r) begin
         if (s_axi_rready) m_r = 1'b0;
      end else if (rh) begin
         m_r = 1'b1;
`ifdef VGA_CFG_SLV_READ_EN
         m_rdata = (s_axi_araddr == 11'h208) ? {14'b0, m_sh_frac, m_sh_int} :
                   (s_axi_araddr == 11'h004) ? 32'(lk) : 32'h0;
         m_rresp = (s_axi_araddr == 11'h208 || s_axi_araddr == 11'h004 || s_axi_araddr == 11'h25C) ? 2'b00 : 2'b10;
`else
         m_rdata = 32'h0;
         m_rresp = 2'b00;
`endif
      end
      n++;
      m_upd = 1'b0;
      if (m_b) begin
         if (s_axi_bready) m_b = 1'b0;
      end else begin
         if (ah) begin m_aw = 1'b1; m_awaddr = s_axi_awaddr; end
         if (wh) begin m_w = 1'b1; m_wdata = s_axi_wdata; m_wstrb = s_axi_wstrb; end
         if (m_aw && m_w) begin
            m_aw = 1'b0; m_w = 1'b0; m_b = 1'b1;
            m_bresp = (m_awaddr == 11'h208 || m_awaddr == 11'h004 || m_awaddr == 11'h25C) ? 2'b00 : 2'b10;
            if (m_awaddr == 11'h208) begin
               if (m_wstrb[0]) m_sh_int = m_wdata[7:0];
               if (m_wstrb[1]) m_sh_frac[7:0] = m_wdata[15:8];
               if (m_wstrb[2]) m_sh_frac[9:8] = m_wdata[17:16];
            end
            if (m_awaddr == 11'h25C && m_wdata[1:0] == 2'b11) begin
               m_int = m_sh_int; m_frac = m_sh_frac; m_upd = 1'b1; m_commit = n;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("awready", 32'(s_axi_awready), 32'(!m_aw && !m_b));
         chk("wready", 32'(s_axi_wready), 32'(!m_w && !m_b));
         chk("bvalid", 32'(s_axi_bvalid), 32'(m_b));
         chk("bresp", 32'(s_axi_bresp), 32'(m_bresp));
         chk("arready", 32'(s_axi_arready), 32'(!m_r));
         chk("rvalid", 32'(s_axi_rvalid), 32'(m_r));
         chk("rresp", 32'(s_axi_rresp), 32'(m_rresp));
         chk("rdata", s_axi_rdata, m_rdata);
         chk("div_int", 32'(div_int_o), 32'(m_int));
         chk("div_frac", 32'(div_frac_o), 32'(m_frac));
         chk("cfg_update", 32'(cfg_update_o), 32'(m_upd));
         chk("locked", 32'(locked_o), 32'((n - m_commit) > LC));
         if (cfg_update_o) upd_cnt++;
      end
   end

   task automatic idle_inputs();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
   endtask

   task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
      bit ah, wh;
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      for (int i = 0; i < 20 && (s_axi_awvalid || s_axi_wvalid); i++) begin
         ah = s_axi_awvalid && !m_aw && !m_b;
         wh = s_axi_wvalid && !m_w && !m_b;
         tick();
         if (ah) s_axi_awvalid = 1'b0;
         if (wh) s_axi_wvalid = 1'b0;
      end
      chk("write_timeout", 32'(s_axi_awvalid || s_axi_wvalid), 32'h0);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      chk("write_bvalid", 32'(s_axi_bvalid), 32'h1);
      resp = s_axi_bresp;
      tick();
   endtask

   task automatic do_read(input logic [10:0] a, output logic [31:0] d, output logic [1:0] resp);
      bit rh;
      s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      for (int i = 0; i < 20 && s_axi_arvalid; i++) begin
         rh = !m_r;
         tick();
         if (rh) s_axi_arvalid = 1'b0;
      end
      chk("read_timeout", 32'(s_axi_arvalid), 32'h0);
      s_axi_arvalid = 1'b0;
      chk("read_rvalid", 32'(s_axi_rvalid), 32'h1);
      d = s_axi_rdata;
      resp = s_axi_rresp;
      tick();
   endtask

   task automatic wait_locked(output int cyc);
      cyc = 0;
      while (!locked_o && cyc < 300) begin
         tick();
         cyc++;
      end
   endtask

   function automatic logic [10:0] pick_addr();
      case ($urandom_range(0, 4))
         0:       return 11'h208;
         1:       return 11'h25C;
         2:       return 11'h004;
         3:       return 11'h100;
         default: return 11'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  b, r;
      logic [31:0] d;
      int          cyc;
      arstn_i = 1'b0;
      s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rst_awready", 32'(s_axi_awready), 32'h1);
      chk("rst_wready", 32'(s_axi_wready), 32'h1);
      chk("rst_arready", 32'(s_axi_arready), 32'h1);
      chk("rst_bvalid", 32'(s_axi_bvalid), 32'h0);
      chk("rst_rvalid", 32'(s_axi_rvalid), 32'h0);
      chk("rst_div_int", 32'(div_int_o), 32'd25);
      chk("rst_locked", 32'(locked_o), 32'h0);
      arstn_i = 1'b1;
      model_init();
      chk_en = 1'b1;

      wait_locked(cyc);
      chk("reset_relock_cycles", 32'(cyc), 32'd65);
      chk("reset_div_frac", 32'(div_frac_o), 32'd0);

      upd_cnt = 0;
      do_write(11'h208, 32'h0000_006C, 4'hF, b);
      chk("cfg_bresp", 32'(b), 32'h0);
      chk("cfg_no_apply", 32'(div_int_o), 32'd25);
      do_write(11'h25C, 32'h3, 4'hF, b);
      chk("ctrl_bresp", 32'(b), 32'h0);
      chk("div_int_108", 32'(div_int_o), 32'd108);
      wait_locked(cyc);
      chk("commit_low_cycles", 32'(cyc + 1), 32'd65);
      chk("update_pulses", 32'(upd_cnt), 32'd1);

      s_axi_awaddr = 11'h208; s_axi_awvalid = 1'b1; s_axi_bready = 1'b0;
      tick();
      s_axi_awvalid = 1'b0;
      repeat (2) tick();
      s_axi_wdata = 32'h0000_0032; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      tick();
      s_axi_wvalid = 1'b0;
      s_axi_awaddr = 11'h004; s_axi_awvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("b_held", 32'(s_axi_bvalid), 32'h1);
         chk("no_second_aw", 32'(s_axi_awready), 32'h0);
         tick();
      end
      s_axi_bready = 1'b1;
      tick();
      chk("aw_after_b", 32'(s_axi_awready), 32'h1);
      tick();
      s_axi_awvalid = 1'b0;
      s_axi_wdata = 32'h0; s_axi_wvalid = 1'b1;
      tick();
      s_axi_wvalid = 1'b0;
      tick();

      wait_locked(cyc);
      do_write(11'h25C, 32'h3, 4'hF, b);
      repeat (LC / 2 - 1) tick();
      chk("mid_relock_low", 32'(locked_o), 32'h0);
      do_write(11'h25C, 32'h3, 4'hF, b);
      wait_locked(cyc);
      chk("restart_low_cycles", 32'(cyc + 1), 32'd65);
      chk("div_int_32", 32'(div_int_o), 32'h32);

      do_write(11'h208, 32'hFFFF_FF40, 4'h1, b);
      chk("strb_div_unchanged", 32'(div_int_o), 32'h32);
      do_read(11'h208, d, r);
`ifdef VGA_CFG_SLV_READ_EN
      chk("read_cfg", d, 32'h40);
`else
      chk("read_cfg", d, 32'h0);
`endif
      chk("read_cfg_resp", 32'(r), 32'h0);
      do_read(11'h100, d, r);
      chk("read_bad_data", d, 32'h0);
`ifdef VGA_CFG_SLV_READ_EN
      chk("read_bad_resp", 32'(r), 32'h2);
`else
      chk("read_bad_resp", 32'(r), 32'h0);
`endif
      do_write(11'h100, 32'h3, 4'hF, b);
      chk("write_bad_resp", 32'(b), 32'h2);

      upd_cnt = 0;
      do_write(11'h25C, 32'h1, 4'hF, b);
      chk("ctrl1_bresp", 32'(b), 32'h0);
      repeat (4) tick();
      chk("ctrl1_no_update", 32'(upd_cnt), 32'h0);
      chk("ctrl1_locked", 32'(locked_o), 32'h1);
      chk("ctrl1_div", 32'(div_int_o), 32'h32);

      s_axi_awaddr = 11'h208; s_axi_wdata = 32'hAB; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
      s_axi_araddr = 11'h004; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
      tick();
      idle_inputs();
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      chk("pre_rst_bvalid", 32'(s_axi_bvalid), 32'h1);
      chk("pre_rst_rvalid", 32'(s_axi_rvalid), 32'h1);
      #2;
      chk_en = 1'b0;
      arstn_i = 1'b0;
      #1;
      chk("async_bvalid", 32'(s_axi_bvalid), 32'h0);
      chk("async_rvalid", 32'(s_axi_rvalid), 32'h0);
      chk("async_div_int", 32'(div_int_o), 32'd25);
      chk("async_locked", 32'(locked_o), 32'h0);
      repeat (2) @(negedge clk);
      idle_inputs();
      arstn_i = 1'b1;
      model_init();
      chk_en = 1'b1;

      s_axi_awaddr = 11'h25C; s_axi_awvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0;
      #2;
      chk_en = 1'b0;
      arstn_i = 1'b0;
      @(negedge clk);
      arstn_i = 1'b1;
      model_init();
      chk_en = 1'b1;
      s_axi_wdata = 32'h3; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      tick();
      s_axi_wvalid = 1'b0;
      chk("aw_discarded", 32'(s_axi_bvalid), 32'h0);
      s_axi_awaddr = 11'h004; s_axi_awvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0;
      tick();

      for (int i = 0; i < 4000; i++) begin
         s_axi_awvalid = 1'($urandom_range(0, 1));
         s_axi_awaddr = pick_addr();
         s_axi_wvalid = 1'($urandom_range(0, 1));
         s_axi_wdata = $urandom;
         if ($urandom_range(0, 9) != 0) s_axi_wdata[1] = 1'b0;
         s_axi_wstrb = 4'($urandom);
         s_axi_bready = ($urandom_range(0, 3) != 0);
         s_axi_arvalid = 1'($urandom_range(0, 1));
         s_axi_araddr = pick_addr();
         s_axi_rready = ($urandom_range(0, 3) != 0);
         tick();
      end
      idle_inputs();
      repeat (LC + 10) tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end
endmodule
